// File: rtl/video_timing_gen.sv
// Raster timing generator: derives a pixel clock-enable from the master clock,
// runs programmable H/V counters and produces blanking, sync, tile-fetch
// strobes, a frame-start strobe, a latched VBLANK IRQ with acknowledge and a
// gated level-sensitive NMI. Every decoded output is registered on the same
// edge as the counters and describes the new counter values.
module video_timing_gen #(
    parameter int CLK_DIV      = 3,
    parameter int HW           = 9,
    parameter int VW           = 9,
    parameter int H_TOTAL      = 384,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 304,
    parameter int H_SYNC_LEN   = 32,
    parameter int V_TOTAL      = 264,
    parameter int V_ACTIVE     = 224,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_LEN   = 8,
    parameter int IRQ_LINE     = 224,
    parameter int FETCH_W      = 3
) (
    input  logic          clk,
    input  logic          reset,
    output logic          ce_pix,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hblank,
    output logic          vblank,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          csync_n,
    output logic          tile_load,
    output logic          frame_start,
    output logic          irq_n,
    input  logic          irq_ack,
    input  logic          nmi_en,
    output logic          nmi_n
);

    // Reject timing sets that would make the counters or decodes meaningless.
    if (!(CLK_DIV >= 1 &&
          H_ACTIVE < H_TOTAL && V_ACTIVE < V_TOTAL &&
          H_SYNC_START + H_SYNC_LEN <= H_TOTAL &&
          V_SYNC_START + V_SYNC_LEN <= V_TOTAL &&
          IRQ_LINE < V_TOTAL &&
          H_TOTAL <= (1 << HW) && V_TOTAL <= (1 << VW) &&
          FETCH_W >= 1 && FETCH_W <= HW)) begin : g_bad_params
        $error("video_timing_gen: invalid timing parameters");
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HW-1:0]      H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]      V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]      IRQ_V     = VW'(IRQ_LINE);
    // One extra bit so that a sync window ending exactly at 2^HW still compares.
    localparam logic [HW:0]        H_ACT     = (HW + 1)'(H_ACTIVE);
    localparam logic [HW:0]        H_SS      = (HW + 1)'(H_SYNC_START);
    localparam logic [HW:0]        H_SE      = (HW + 1)'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [VW:0]        V_ACT     = (VW + 1)'(V_ACTIVE);
    localparam logic [VW:0]        V_SS      = (VW + 1)'(V_SYNC_START);
    localparam logic [VW:0]        V_SE      = (VW + 1)'(V_SYNC_START + V_SYNC_LEN);
    localparam logic [FETCH_W-1:0] TILE_LAST = '1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             ce_q, ce_d;
    logic [HW-1:0]    hcount_q, hcount_d;
    logic [VW-1:0]    vcount_q, vcount_d;
    logic             hblank_q, hblank_d;
    logic             vblank_q, vblank_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             csync_q;
    logic             tile_q, tile_d;
    logic             frame_q, frame_d;
    logic             irq_q, irq_d;
    logic             irq_set;
    logic             nmi_q, nmi_d;

    // Next-state: divider, counters and decodes of the counter values being loaded.
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        ce_d     = (div_d == DIV_LAST);

        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (ce_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
            end else begin
                hcount_d = hcount_q + HW'(1);
            end
        end

        hblank_d = ({1'b0, hcount_d} >= H_ACT);
        vblank_d = ({1'b0, vcount_d} >= V_ACT);
        hsync_d  = !(({1'b0, hcount_d} >= H_SS) && ({1'b0, hcount_d} < H_SE));
        vsync_d  = !(({1'b0, vcount_d} >= V_SS) && ({1'b0, vcount_d} < V_SE));

        // Strobes fire only on the edge that actually moves the counters.
        tile_d   = ce_q && (hcount_d[FETCH_W-1:0] == TILE_LAST);
        frame_d  = ce_q && (hcount_d == '0) && (vcount_d == '0);
        irq_set  = ce_q && (hcount_d == '0) && (vcount_d == IRQ_V);

        // A set on the same edge as an acknowledge wins.
        if (irq_set) begin
            irq_d = 1'b0;
        end else if (irq_ack) begin
            irq_d = 1'b1;
        end else begin
            irq_d = irq_q;
        end

        nmi_d = !(vblank_d && nmi_en);
    end

    // State and registered outputs; async reset returns everything to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            ce_q     <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            csync_q  <= 1'b1;
            tile_q   <= 1'b0;
            frame_q  <= 1'b0;
            irq_q    <= 1'b1;
            nmi_q    <= 1'b1;
        end else begin
            div_q    <= div_d;
            ce_q     <= ce_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            csync_q  <= hsync_d & vsync_d;
            tile_q   <= tile_d;
            frame_q  <= frame_d;
            irq_q    <= irq_d;
            nmi_q    <= nmi_d;
        end
    end

    assign ce_pix      = ce_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign hsync_n     = hsync_q;
    assign vsync_n     = vsync_q;
    assign csync_n     = csync_q;
    assign tile_load   = tile_q;
    assign frame_start = frame_q;
    assign irq_n       = irq_q;
    assign nmi_n       = nmi_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three builds (default timing, a small CLK_DIV=3
// raster and a tiny CLK_DIV=1 raster) run in lockstep against an arithmetic
// model that derives every output from the number of clock edges since reset.
module tb_video_timing_gen;

    typedef struct packed {
        logic        ce;
        logic [15:0] hc;
        logic [15:0] vc;
        logic        hb, vb, hs, vs, cs, tl, fs, irq, nmi;
    } outs_t;

    // Per-build timing: index 0 = defaults, 1 = small, 2 = tiny CLK_DIV=1.
    localparam int D_C   [3] = '{3, 3, 1};
    localparam int HT_C  [3] = '{384, 40, 16};
    localparam int HA_C  [3] = '{256, 32, 12};
    localparam int HSS_C [3] = '{304, 34, 12};
    localparam int HSL_C [3] = '{32, 4, 2};
    localparam int VT_C  [3] = '{264, 20, 8};
    localparam int VA_C  [3] = '{224, 16, 6};
    localparam int VSS_C [3] = '{240, 17, 6};
    localparam int VSL_C [3] = '{8, 2, 1};
    localparam int IRQ_C [3] = '{224, 16, 6};
    localparam int F_C   [3] = '{3, 3, 3};

    localparam outs_t RST_V = {1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                               1'b0, 1'b0, 1'b1, 1'b1};

    logic clk = 1'b0;
    logic reset;
    logic irq_ack;
    logic nmi_en;

    always #5 clk = ~clk;

    logic       a_ce, a_hb, a_vb, a_hs, a_vs, a_cs, a_tl, a_fs, a_irq, a_nmi;
    logic [8:0] a_hc, a_vc;
    logic       b_ce, b_hb, b_vb, b_hs, b_vs, b_cs, b_tl, b_fs, b_irq, b_nmi;
    logic [5:0] b_hc;
    logic [4:0] b_vc;
    logic       c_ce, c_hb, c_vb, c_hs, c_vs, c_cs, c_tl, c_fs, c_irq, c_nmi;
    logic [3:0] c_hc;
    logic [2:0] c_vc;

    video_timing_gen u_a (
        .clk(clk), .reset(reset), .ce_pix(a_ce), .hcount(a_hc), .vcount(a_vc),
        .hblank(a_hb), .vblank(a_vb), .hsync_n(a_hs), .vsync_n(a_vs), .csync_n(a_cs),
        .tile_load(a_tl), .frame_start(a_fs), .irq_n(a_irq), .irq_ack(irq_ack),
        .nmi_en(nmi_en), .nmi_n(a_nmi)
    );

    video_timing_gen #(
        .CLK_DIV(D_C[1]), .HW(6), .VW(5), .H_TOTAL(HT_C[1]), .H_ACTIVE(HA_C[1]),
        .H_SYNC_START(HSS_C[1]), .H_SYNC_LEN(HSL_C[1]), .V_TOTAL(VT_C[1]),
        .V_ACTIVE(VA_C[1]), .V_SYNC_START(VSS_C[1]), .V_SYNC_LEN(VSL_C[1]),
        .IRQ_LINE(IRQ_C[1]), .FETCH_W(F_C[1])
    ) u_b (
        .clk(clk), .reset(reset), .ce_pix(b_ce), .hcount(b_hc), .vcount(b_vc),
        .hblank(b_hb), .vblank(b_vb), .hsync_n(b_hs), .vsync_n(b_vs), .csync_n(b_cs),
        .tile_load(b_tl), .frame_start(b_fs), .irq_n(b_irq), .irq_ack(irq_ack),
        .nmi_en(nmi_en), .nmi_n(b_nmi)
    );

    video_timing_gen #(
        .CLK_DIV(D_C[2]), .HW(4), .VW(3), .H_TOTAL(HT_C[2]), .H_ACTIVE(HA_C[2]),
        .H_SYNC_START(HSS_C[2]), .H_SYNC_LEN(HSL_C[2]), .V_TOTAL(VT_C[2]),
        .V_ACTIVE(VA_C[2]), .V_SYNC_START(VSS_C[2]), .V_SYNC_LEN(VSL_C[2]),
        .IRQ_LINE(IRQ_C[2]), .FETCH_W(F_C[2])
    ) u_c (
        .clk(clk), .reset(reset), .ce_pix(c_ce), .hcount(c_hc), .vcount(c_vc),
        .hblank(c_hb), .vblank(c_vb), .hsync_n(c_hs), .vsync_n(c_vs), .csync_n(c_cs),
        .tile_load(c_tl), .frame_start(c_fs), .irq_n(c_irq), .irq_ack(irq_ack),
        .nmi_en(nmi_en), .nmi_n(c_nmi)
    );

    outs_t act [3];

    always_comb begin
        act[0] = {a_ce, 16'(a_hc), 16'(a_vc), a_hb, a_vb, a_hs, a_vs, a_cs, a_tl, a_fs, a_irq, a_nmi};
        act[1] = {b_ce, 16'(b_hc), 16'(b_vc), b_hb, b_vb, b_hs, b_vs, b_cs, b_tl, b_fs, b_irq, b_nmi};
        act[2] = {c_ce, 16'(c_hc), 16'(c_vc), c_hb, c_vb, c_hs, c_vs, c_cs, c_tl, c_fs, c_irq, c_nmi};
    end

    // Outputs after tt edges since reset release, from the raster arithmetic alone.
    function automatic outs_t model(int i, int tt);
        outs_t o;
        int    n, h, v, tw;
        bit    pc;
        n    = (D_C[i] == 1) ? ((tt >= 1) ? tt - 1 : 0) : tt / D_C[i];
        h    = n % HT_C[i];
        v    = (n / HT_C[i]) % VT_C[i];
        pc   = (tt >= 2) && ((tt - 1) % D_C[i] == D_C[i] - 1);
        tw   = 1 << F_C[i];
        o.ce = (tt >= 1) && (tt % D_C[i] == D_C[i] - 1);
        o.hc = 16'(h);
        o.vc = 16'(v);
        o.hb = (h >= HA_C[i]);
        o.vb = (v >= VA_C[i]);
        o.hs = !(h >= HSS_C[i] && h < HSS_C[i] + HSL_C[i]);
        o.vs = !(v >= VSS_C[i] && v < VSS_C[i] + VSL_C[i]);
        o.cs = o.hs & o.vs;
        o.tl = pc && (h % tw == tw - 1);
        o.fs = pc && (h == 0) && (v == 0);
        o.irq = 1'b1;
        o.nmi = 1'b1;
        return o;
    endfunction

    function automatic bit irq_set_at(int i, int tt);
        outs_t c, nx;
        c  = model(i, tt);
        nx = model(i, tt + 1);
        return c.ce && (nx.hc == 16'd0) && (nx.vc == 16'(IRQ_C[i]));
    endfunction

    function automatic bit vb_at(int i, int tt);
        outs_t o;
        o = model(i, tt);
        return o.vb;
    endfunction

    int       t;
    logic [2:0] irq_m;
    logic [2:0] nmi_m;

    // Edge counter plus the two stateful outputs (IRQ latch, NMI gate).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t     <= 0;
            irq_m <= 3'b111;
            nmi_m <= 3'b111;
        end else begin
            t <= t + 1;
            for (int i = 0; i < 3; i++) begin
                if (irq_set_at(i, t)) irq_m[i] <= 1'b0;
                else if (irq_ack)     irq_m[i] <= 1'b1;
                nmi_m[i] <= !(vb_at(i, t + 1) && nmi_en);
            end
        end
    end

    function automatic outs_t exp_of(int i);
        outs_t e;
        e     = model(i, t);
        e.irq = irq_m[i];
        e.nmi = nmi_m[i];
        return e;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic test_reset();
        reset   = 1'b1;
        irq_ack = 1'b0;
        nmi_en  = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (act[i] !== RST_V) begin
                n_bad++;
                $display("FAIL reset_values inst%0d got=%h expected=%h", i, act[i], RST_V);
            end
        end
    endtask

    task automatic test_ce_timing();
        outs_t e;
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            // Divider reaches 2 after edge 2, so edge 3 is the first to see ce_pix.
            n_cmp++;
            if (a_ce !== (k % 3 == 2)) begin
                n_bad++;
                $display("FAIL ce_default k=%0d got=%b expected=%b", k, a_ce, (k % 3 == 2));
            end
            n_cmp++;
            if (c_ce !== 1'b1) begin
                n_bad++;
                $display("FAIL ce_div1 k=%0d got=%b expected=1", k, c_ce);
            end
            for (int i = 0; i < 3; i++) begin
                e = exp_of(i);
                n_cmp++;
                if (act[i] !== e) begin
                    n_bad++;
                    $display("FAIL ce_model inst%0d t=%0d got=%h expected=%h", i, t, act[i], e);
                end
            end
        end
    endtask

    task automatic test_lines();
        outs_t e;
        int last_wrap = -1;
        int hs_cnt = 0, hb_cnt = 0, lines = 0;
        logic [15:0] prev_hc;
        logic prev_hs;
        prev_hc = act[0].hc;
        prev_hs = act[0].hs;
        for (int k = 0; k < 3600; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e = exp_of(i);
                n_cmp++;
                if (act[i] !== e) begin
                    n_bad++;
                    $display("FAIL lines_model inst%0d t=%0d got=%h expected=%h", i, t, act[i], e);
                end
            end
            if (act[0].hc == 16'd0 && prev_hc == 16'd383) begin
                if (last_wrap >= 0) begin
                    lines++;
                    n_cmp++;
                    if (t - last_wrap != 1152 || hs_cnt != 96 || hb_cnt != 384) begin
                        n_bad++;
                        $display("FAIL line_period got=%0d/%0d/%0d expected=1152/96/384",
                                 t - last_wrap, hs_cnt, hb_cnt);
                    end
                end
                last_wrap = t;
                hs_cnt    = 0;
                hb_cnt    = 0;
            end
            if (!act[0].hs) hs_cnt++;
            if (act[0].hb) hb_cnt++;
            if (prev_hs && !act[0].hs) begin
                n_cmp++;
                if (act[0].hc !== 16'd304) begin
                    n_bad++;
                    $display("FAIL hsync_start got=%0d expected=304", act[0].hc);
                end
            end
            prev_hc = act[0].hc;
            prev_hs = act[0].hs;
        end
        n_cmp++;
        if (lines < 2) begin
            n_bad++;
            $display("FAIL line_count got=%0d expected>=2", lines);
        end
    endtask

    task automatic test_frames_random();
        outs_t e;
        int last_fs [3] = '{-1, -1, -1};
        int periods = 0;
        logic prev_vs;
        prev_vs = act[1].vs;
        for (int k = 0; k < 5200; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e = exp_of(i);
                n_cmp++;
                if (act[i] !== e) begin
                    n_bad++;
                    $display("FAIL frames_model inst%0d t=%0d got=%h expected=%h", i, t, act[i], e);
                end
            end
            for (int i = 1; i < 3; i++) begin
                if (act[i].fs) begin
                    if (last_fs[i] >= 0) begin
                        periods++;
                        n_cmp++;
                        if (t - last_fs[i] != D_C[i] * HT_C[i] * VT_C[i]) begin
                            n_bad++;
                            $display("FAIL frame_period inst%0d got=%0d expected=%0d", i,
                                     t - last_fs[i], D_C[i] * HT_C[i] * VT_C[i]);
                        end
                    end
                    last_fs[i] = t;
                end
            end
            if (prev_vs && !act[1].vs) begin
                n_cmp++;
                if (act[1].vc !== 16'd17) begin
                    n_bad++;
                    $display("FAIL vsync_start got=%0d expected=17", act[1].vc);
                end
            end
            prev_vs = act[1].vs;
            irq_ack = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0) nmi_en = !nmi_en;
        end
        irq_ack = 1'b0;
        nmi_en  = 1'b0;
        n_cmp++;
        if (periods < 3) begin
            n_bad++;
            $display("FAIL frame_count got=%0d expected>=3", periods);
        end
    endtask

    // Park at the clock just before the small build's counters enter (0,16).
    task automatic wait_pre_irq(output bit found);
        found = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (act[1].ce && act[1].hc == 16'd39 && act[1].vc == 16'd15) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_irq_handshake();
        bit found;
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (b_irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_cleared got=%b expected=1", b_irq);
        end
        wait_pre_irq(found);
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL irq_wait timeout got=0 expected=1");
        end
        @(negedge clk);
        n_cmp++;
        if ({b_irq, act[1].hc, act[1].vc} !== {1'b0, 16'd0, 16'd16}) begin
            n_bad++;
            $display("FAIL irq_set got=%b@(%0d,%0d) expected=0@(0,16)", b_irq, act[1].hc, act[1].vc);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (b_irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_hold got=%b expected=0", b_irq);
        end
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        n_cmp++;
        if (b_irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_ack_release got=%b expected=1", b_irq);
        end
        irq_ack = 1'b1;
        repeat (3) @(negedge clk);
        irq_ack = 1'b0;
        n_cmp++;
        if (b_irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_ack_idle got=%b expected=1", b_irq);
        end
        wait_pre_irq(found);
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL irq_wait2 timeout got=0 expected=1");
        end
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        n_cmp++;
        if (b_irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_set_wins got=%b expected=0", b_irq);
        end
        @(negedge clk);
        n_cmp++;
        if (b_irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_after_collision got=%b expected=0", b_irq);
        end
    endtask

    task automatic test_nmi();
        bit found = 1'b0;
        int vb_clks = 0;
        nmi_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2400; k++) begin
            @(negedge clk);
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (act[i].nmi !== !act[i].vb) begin
                    n_bad++;
                    $display("FAIL nmi_gate inst%0d got=%b expected=%b", i, act[i].nmi, !act[i].vb);
                end
            end
            if (act[1].vb) vb_clks++;
        end
        n_cmp++;
        if (vb_clks != 4 * 40 * 3) begin
            n_bad++;
            $display("FAIL vblank_clks got=%0d expected=480", vb_clks);
        end
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (act[1].vb && act[1].vc == 16'd17) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found || b_nmi !== 1'b0) begin
            n_bad++;
            $display("FAIL nmi_in_vblank got=%b/%b expected=1/0", found, b_nmi);
        end
        nmi_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({b_nmi, b_vb} !== 2'b11) begin
            n_bad++;
            $display("FAIL nmi_release got=%b%b expected=11", b_nmi, b_vb);
        end
    endtask

    task automatic test_mid_reset();
        outs_t e;
        bit found = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (act[1].hc == 16'd20 && act[1].vc == 16'd10) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found || b_irq !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_irq_pending got=%b/%b expected=1/0", found, b_irq);
        end
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (act[i] !== RST_V) begin
                n_bad++;
                $display("FAIL mid_reset_values inst%0d got=%h expected=%h", i, act[i], RST_V);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e = exp_of(i);
                n_cmp++;
                if (act[i] !== e) begin
                    n_bad++;
                    $display("FAIL restart_model inst%0d t=%0d got=%h expected=%h", i, t, act[i], e);
                end
            end
        end
        n_cmp++;
        if (b_irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_after_reset got=%b expected=1", b_irq);
        end
    endtask

    initial begin
        test_reset();
        test_ce_timing();
        test_lines();
        test_frames_random();
        test_irq_handshake();
        test_nmi();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator. It replaces the hard-wired H/V counter chain, the sync/blank decode and the VBLANK interrupt flops of the arcade board tops. It derives a pixel clock-enable from the master clock, runs programmable horizontal and vertical counters, and emits blanking, sync, tile-fetch strobes and a latched IRQ with acknowledge handshake. It also drives a gated NMI. It sits between the master clock and the video fetch/render and CPU interrupt logic.

Parameters:
CLK_DIV, 3, master clocks per pixel (>=1; 18 MHz -> 6 MHz)
HW, 9, hcount width
VW, 9, vcount width
H_TOTAL, 384, pixels per line
H_ACTIVE, 256, visible pixels, hcount 0..H_ACTIVE-1
H_SYNC_START, 304, first hcount with hsync_n low
H_SYNC_LEN, 32, hsync width in pixels
V_TOTAL, 264, lines per frame
V_ACTIVE, 224, visible lines
V_SYNC_START, 240, first vcount with vsync_n low
V_SYNC_LEN, 8, vsync width in lines
IRQ_LINE, 224, vcount at which the IRQ is raised
FETCH_W, 3, log2 of tile width; tile_load fires every 2^FETCH_W pixels

Ports:
clk in 1 master clock, all logic on rising edge
reset in 1 asynchronous, active-high
ce_pix out 1 one-clk pixel enable
hcount out HW current pixel column
vcount out VW current line
hblank out 1 high when hcount >= H_ACTIVE
vblank out 1 high when vcount >= V_ACTIVE
hsync_n out 1 active-low horizontal sync
vsync_n out 1 active-low vertical sync
csync_n out 1 hsync_n AND vsync_n
tile_load out 1 one-clk strobe, last pixel of each tile
frame_start out 1 one-clk strobe when counters enter (0,0)
irq_n out 1 latched active-low interrupt
irq_ack in 1 CPU interrupt acknowledge, sampled each clk
nmi_en in 1 NMI enable latch bit
nmi_n out 1 active-low NMI

Behaviour:
- Reset (async): divider=0, hcount=0, vcount=0, ce_pix=0, hblank=0, vblank=0, hsync_n=1, vsync_n=1, csync_n=1, tile_load=0, frame_start=0, irq_n=1, nmi_n=1.
- Divider: counts 0..CLK_DIV-1 and wraps. ce_pix is registered and high for the one clk in which divider==CLK_DIV-1. For CLK_DIV=1, ce_pix is high every clk after the first post-reset edge.
- Counters: advance only on clk with ce_pix=1. hcount==H_TOTAL-1 -> hcount=0 and vcount advances. vcount==V_TOTAL-1 on that wrap -> vcount=0.
- All decoded outputs are registered on the same edge as the counters and describe the new counter values. No extra pipeline latency versus hcount/vcount.
- hsync_n=0 for hcount in [H_SYNC_START, H_SYNC_START+H_SYNC_LEN). vsync_n uses the same rule on vcount with the V_ parameters. Ranges do not wrap past the total; the parameter check forbids that.
- tile_load=1 for one clk, on the ce_pix edge entering hcount with low FETCH_W bits all ones.
- frame_start=1 for one clk on the edge where the counters become (0,0).
- IRQ: irq_n goes to 0 on the edge where the counters become (0, IRQ_LINE). It holds until a clk with irq_ack=1, which sets irq_n=1 on the next edge. If set and ack happen in the same clk, set wins and irq_n=0. Ack while irq_n=1 has no effect.
- NMI: nmi_n is registered from ~(vblank_next AND nmi_en) every clk. It is level-sensitive, so dropping nmi_en releases nmi_n on the next edge.
- Reset mid-frame: immediate return to reset values. Counting resumes from (0,0) after release, and any pending IRQ is cleared.
- Elaboration check, invalid parameters stop elaboration with an error: H_ACTIVE<H_TOTAL; V_ACTIVE<V_TOTAL; H_SYNC_START+H_SYNC_LEN<=H_TOTAL; V_SYNC_START+V_SYNC_LEN<=V_TOTAL; IRQ_LINE<V_TOTAL; H_TOTAL<=2^HW; V_TOTAL<=2^VW; CLK_DIV>=1.

Test Plan:
- Reset values, defaults: hold reset 10 clks -> every output at its listed reset value. Release -> first ce_pix at clk 3, then every 3 clks.
- Line/frame period: run 2 frames -> hcount wraps every 1152 clks; frame_start every 1152*264=304128 clks; hblank high for 128 pixels per line.
- Sync widths: hsync_n low exactly 32 pixels starting at hcount 304. vsync_n low lines 240..247. csync_n equals their AND throughout.
- IRQ handshake: irq_n falls at (0,224). Ack pulse 5 clks later -> irq_n=1 on the next edge. Ack asserted on the set edge -> irq_n stays 0.
- NMI gating: nmi_en=1 -> nmi_n low exactly while vblank=1. Drop nmi_en mid-vblank -> nmi_n=1 one clk later.
- Mid-frame reset plus CLK_DIV=1 build: pulse reset at (100,50) with irq_n=0 -> all outputs reset and irq_n=1. With CLK_DIV=1, H_TOTAL=16, V_TOTAL=8 -> frame_start every 128 clks; tile_load at hcount 7 and 15.
